// File: rtl/ecc_pkg.sv
// Shared definitions for the extended-Hamming SEC/DED code: check-bit sizing,
// data-bit placement inside the codeword, and the decode status encoding.
// Used by the syndrome network, the pipelined decoder and the future encoder.
package ecc_pkg;

  typedef enum logic [1:0] {
    CLEAN = 2'd0,
    SEC   = 2'd1,
    DED   = 2'd2
  } dec_status_e;

  // Total check bits (r Hamming bits + 1 overall parity) for a data width.
  // r is the smallest value with 2^r >= data_w + r + 1.
  function automatic int chk_w(input int data_w);
    int r;
    r = 1;
    for (int k = 8; k >= 1; k--) begin
      if ((1 << k) >= data_w + k + 1) r = k;
    end
    return r + 1;
  endfunction

  // Codeword position (1-based) of data bit idx: data bits occupy the
  // non-power-of-two positions in ascending order (bit0 at 3, bit1 at 5, ...).
  function automatic int data_pos(input int idx);
    int pos;
    int cnt;
    pos = 0;
    cnt = 0;
    for (int p = 3; p < 512; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == idx && pos == 0) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/ecc_syndrome.sv
// Hamming syndrome / check-bit network: o_syn = recomputed check bits ^ i_chk[r-1:0].
// Latency: combinational. With i_chk = 0, o_syn gives the encoder's check bits.
// Backpressure: none (pure logic); o_par is even parity over data and all check bits.
module ecc_syndrome
  import ecc_pkg::*;
#(
  parameter int  DATA_W = 32,
  localparam int CHK_W  = chk_w(DATA_W),
  localparam int R      = CHK_W - 1
) (
  input  logic [DATA_W-1:0] i_data,
  input  logic [CHK_W-1:0]  i_chk,
  output logic [R-1:0]      o_syn,
  output logic              o_par
);

  // Each set data bit contributes its codeword position to the syndrome.
  logic [R-1:0] w_contrib [DATA_W];

  for (genvar g = 0; g < DATA_W; g++) begin : g_contrib
    localparam logic [R-1:0] POS = R'(data_pos(g));
    assign w_contrib[g] = i_data[g] ? POS : '0;
  end

  // XOR of all contributing positions against the received Hamming bits.
  always_comb begin
    o_syn = i_chk[R-1:0];
    for (int i = 0; i < DATA_W; i++) begin
      o_syn = o_syn ^ w_contrib[i];
    end
  end

  assign o_par = ^{i_data, i_chk};

endmodule

// File: rtl/secded_decoder_pipe.sv
// Pipelined SEC/DED decoder: corrects single-bit errors, flags double errors.
// Latency: 2 cycles (syndrome stage, decode stage), 1 word/cycle throughput.
// Backpressure: stages load when empty or when the next stage loads; ECC_ERR_CNT_EN adds error counters.
module secded_decoder_pipe
  import ecc_pkg::*;
#(
  parameter int  DATA_W = 32,
  parameter int  CNT_W  = 16,
  localparam int CHK_W  = chk_w(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CHK_W-1:0]  in_check,
  input  logic              correct_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sec,
  output logic              out_ded,
  output logic [CHK_W-1:0]  out_syndrome,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  sec_cnt,
  output logic [CNT_W-1:0]  ded_cnt
);

  localparam int R = CHK_W - 1;
  // Highest valid codeword position; larger syndromes cannot be single errors.
  localparam logic [R-1:0] MAX_POS = R'(DATA_W + R);

  logic [R-1:0] w_syn;
  logic         w_par;

  ecc_syndrome #(.DATA_W(DATA_W)) u_syndrome (
    .i_data (in_data),
    .i_chk  (in_check),
    .o_syn  (w_syn),
    .o_par  (w_par)
  );

  // Stage 1 registers
  logic              r_s1_vld;
  logic [DATA_W-1:0] r_s1_data;
  logic              r_s1_corr;
  logic [R-1:0]      r_s1_syn;
  logic              r_s1_par;

  // Stage 2 (output) registers
  logic              r_out_vld;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_sec;
  logic              r_out_ded;
  logic [CHK_W-1:0]  r_out_syn;

  logic w_s1_load;
  logic w_s2_load;

  assign w_s2_load = !r_out_vld || out_ready;
  assign w_s1_load = !r_s1_vld || w_s2_load;
  assign in_ready  = w_s1_load;

  // Stage 1: capture the word with its syndrome and parity mismatch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_vld  <= 1'b0;
      r_s1_data <= '0;
      r_s1_corr <= 1'b0;
      r_s1_syn  <= '0;
      r_s1_par  <= 1'b0;
    end else if (w_s1_load) begin
      r_s1_vld <= in_valid;
      if (in_valid) begin
        r_s1_data <= in_data;
        r_s1_corr <= correct_en;
        r_s1_syn  <= w_syn;
        r_s1_par  <= w_par;
      end
    end
  end

  // One-hot flip mask: the data bit whose position equals the syndrome.
  logic [DATA_W-1:0] w_hit;

  for (genvar g = 0; g < DATA_W; g++) begin : g_hit
    localparam logic [R-1:0] POS = R'(data_pos(g));
    assign w_hit[g] = (r_s1_syn == POS);
  end

  dec_status_e       w_status;
  logic [DATA_W-1:0] w_dec_data;

  // Decode: classify the error and correct a data bit when allowed.
  always_comb begin
    w_status   = CLEAN;
    w_dec_data = r_s1_data;
    if (r_s1_par) begin
      if (r_s1_syn == '0) begin
        w_status = SEC;
      end else if (r_s1_syn <= MAX_POS) begin
        w_status = SEC;
        if (r_s1_corr) w_dec_data = r_s1_data ^ w_hit;
      end else begin
        w_status = DED;
      end
    end else if (r_s1_syn != '0) begin
      w_status = DED;
    end
  end

  // Stage 2: register decoded word; holds while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_vld  <= 1'b0;
      r_out_data <= '0;
      r_out_sec  <= 1'b0;
      r_out_ded  <= 1'b0;
      r_out_syn  <= '0;
    end else if (w_s2_load) begin
      r_out_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_out_data <= w_dec_data;
        r_out_sec  <= (w_status == SEC);
        r_out_ded  <= (w_status == DED);
        r_out_syn  <= {r_s1_par, r_s1_syn};
      end
    end
  end

  assign out_valid    = r_out_vld;
  assign out_data     = r_out_data;
  assign out_sec      = r_out_sec;
  assign out_ded      = r_out_ded;
  assign out_syndrome = r_out_syn;

`ifdef ECC_ERR_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_sec_cnt;
  logic [CNT_W-1:0] r_ded_cnt;
  logic             w_out_hs;

  assign w_out_hs = r_out_vld && out_ready;

  // Count delivered error words; clear beats increment, counts saturate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sec_cnt <= '0;
      r_ded_cnt <= '0;
    end else if (cnt_clr) begin
      r_sec_cnt <= '0;
      r_ded_cnt <= '0;
    end else if (w_out_hs) begin
      if (r_out_sec && r_sec_cnt != CNT_MAX) r_sec_cnt <= r_sec_cnt + 1'b1;
      if (r_out_ded && r_ded_cnt != CNT_MAX) r_ded_cnt <= r_ded_cnt + 1'b1;
    end
  end

  assign sec_cnt = r_sec_cnt;
  assign ded_cnt = r_ded_cnt;
`else
  logic w_unused_cnt_clr;
  assign w_unused_cnt_clr = cnt_clr;
  assign sec_cnt = '0;
  assign ded_cnt = '0;
`endif

endmodule

// File: tb/tb_secded_decoder_pipe.sv
// Scoreboard bench for secded_decoder_pipe (DATA_W=32, CNT_W=4).
// Stimulus pushes expected words into a queue; a negedge monitor pops and compares.
// Counter expectations collapse to zero when ECC_ERR_CNT_EN is not defined.
module tb_secded_decoder_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid, in_ready, correct_en;
  logic [31:0] in_data;
  logic [6:0]  in_check;
  logic        out_valid, out_ready, out_sec, out_ded;
  logic [31:0] out_data;
  logic [6:0]  out_syndrome;
  logic        cnt_clr;
  logic [3:0]  sec_cnt, ded_cnt;

  secded_decoder_pipe #(.DATA_W(32), .CNT_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_check     (in_check),
    .correct_en   (correct_en),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_sec      (out_sec),
    .out_ded      (out_ded),
    .out_syndrome (out_syndrome),
    .cnt_clr      (cnt_clr),
    .sec_cnt      (sec_cnt),
    .ded_cnt      (ded_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        sec;
    logic        ded;
    logic [6:0]  syn;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_out = 0;

  logic [31:0] sw_d [6];
  logic [6:0]  sw_c [6];
  logic [31:0] sat_d [5];
  logic [6:0]  sat_s [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int expc(input int v);
`ifdef ECC_ERR_CNT_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  // Monitor: compare every delivered word, and check outputs hold while stalled.
  logic        st_prev = 1'b0;
  logic [40:0] st_val;
  always @(negedge clk) begin
    if (rst) begin
      st_prev = 1'b0;
    end else begin
      if (st_prev)
        check("stall_hold", {1'b0, out_valid, out_data, out_sec, out_ded, out_syndrome},
              {1'b0, 1'b1, st_val});
      if (out_valid && out_ready) begin
        n_out++;
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_word: got data 0x%0h, expected no output", out_data);
        end else begin
          e = q.pop_front();
          check("out_data", out_data, e.data);
          check("out_sec", out_sec, e.sec);
          check("out_ded", out_ded, e.ded);
          check("out_syndrome", out_syndrome, e.syn);
        end
      end
      st_prev = out_valid && !out_ready;
      st_val  = {out_data, out_sec, out_ded, out_syndrome};
    end
  end

  task automatic send(input logic [31:0] d, input logic [6:0] c, input logic ce,
                      input logic [31:0] ed, input logic es, input logic ede,
                      input logic [6:0] esyn, input bit push);
    int w;
    in_valid   = 1'b1;
    in_data    = d;
    in_check   = c;
    correct_en = ce;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 100) begin
      w++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got in_ready 0, expected 1");
    end
    @(posedge clk);
    if (push) q.push_back({ed, es, ede, esyn});
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (q.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("drain_pending", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   sent;
    int   n0;
    int   w;
    logic acc;

    sw_d[0] = 32'h0;        sw_c[0] = 7'h00;
    sw_d[1] = 32'h1;        sw_c[1] = 7'h43;
    sw_d[2] = 32'h2;        sw_c[2] = 7'h45;
    sw_d[3] = 32'h3;        sw_c[3] = 7'h06;
    sw_d[4] = 32'h10;       sw_c[4] = 7'h49;
    sw_d[5] = 32'h80000000; sw_c[5] = 7'h26;
    sat_d[0] = 32'h1;        sat_s[0] = 7'h43;
    sat_d[1] = 32'h2;        sat_s[1] = 7'h45;
    sat_d[2] = 32'h10;       sat_s[2] = 7'h49;
    sat_d[3] = 32'h20;       sat_s[3] = 7'h4A;
    sat_d[4] = 32'h80000000; sat_s[4] = 7'h66;

    in_valid = 0; in_data = 0; in_check = 0; correct_en = 1;
    out_ready = 1; cnt_clr = 0; rst = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_syndrome", out_syndrome, 0);
    check("rst_sec_cnt", sec_cnt, 0);
    rst = 0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Clean word and two-stage latency
    send(32'h0, 7'h00, 1, 32'h0, 0, 0, 7'h00, 1);
    @(negedge clk);
    check("lat_not_yet", out_valid, 0);
    @(negedge clk);
    check("lat_valid", out_valid, 1);
    drain();

    // Directed single/double error vectors
    send(32'h20, 7'h00, 1, 32'h0, 1, 0, 7'h4A, 1);
    send(32'h20, 7'h00, 0, 32'h20, 1, 0, 7'h4A, 1);
    send(32'h3, 7'h00, 1, 32'h3, 0, 1, 7'h06, 1);
    send(32'h0, 7'h40, 1, 32'h0, 1, 0, 7'h40, 1);
    send(32'h0, 7'h01, 1, 32'h0, 1, 0, 7'h41, 1);
    send(32'h0, 7'h7F, 1, 32'h0, 0, 1, 7'h7F, 1);
    send(32'h80000000, 7'h00, 1, 32'h0, 1, 0, 7'h66, 1);
    drain();
    check("cnt_sec_after_vectors", sec_cnt, expc(5));
    check("cnt_ded_after_vectors", ded_cnt, expc(2));

    // Six clean words, consumer stalls on cycles 3..7
    sent = 0;
    for (int c = 0; c < 60 && sent < 6; c++) begin
      out_ready  = !(c >= 3 && c <= 7);
      in_valid   = 1'b1;
      in_data    = sw_d[sent];
      in_check   = sw_c[sent];
      correct_en = 1'b1;
      @(negedge clk);
      acc = in_ready;
      if (c == 5) check("stall_in_ready", in_ready, 0);
      @(posedge clk);
      if (acc) begin
        q.push_back({sw_d[sent], 1'b0, 1'b0, 7'h00});
        sent++;
      end
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stall_sent", sent, 6);
    drain();

    // Saturation of the single-error counter
    for (int k = 0; k < 20; k++)
      send(sat_d[k % 5], 7'h00, 1, 32'h0, 1, 0, sat_s[k % 5], 1);
    drain();
    check("cnt_sec_saturated", sec_cnt, expc(15));
    check("cnt_ded_held", ded_cnt, expc(2));

    // Clear coincident with a SEC handshake
    send(32'h20, 7'h00, 1, 32'h0, 1, 0, 7'h4A, 1);
    w = 0;
    @(negedge clk);
    while (!out_valid && w < 20) begin
      w++;
      @(negedge clk);
    end
    check("clr_out_valid", out_valid, 1);
    cnt_clr = 1'b1;
    @(posedge clk);
    #1 cnt_clr = 1'b0;
    check("clr_sec_cnt", sec_cnt, 0);
    check("clr_ded_cnt", ded_cnt, 0);
    send(32'h10, 7'h00, 1, 32'h0, 1, 0, 7'h49, 1);
    drain();
    check("cnt_after_clr", sec_cnt, expc(1));

    // Reset with two words in flight
    out_ready = 1'b0;
    send(32'h20, 7'h00, 0, 32'h0, 0, 0, 7'h00, 0);
    send(32'h3, 7'h00, 1, 32'h0, 0, 0, 7'h00, 0);
    check("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_out_sec", out_sec, 0);
    check("midrst_out_syndrome", out_syndrome, 0);
    check("midrst_sec_cnt", sec_cnt, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    n0 = n_out;
    repeat (10) @(posedge clk);
    #1;
    check("rst_flushed", n_out, n0);
    check("post_rst_in_ready", in_ready, 1);
    send(32'h1, 7'h43, 1, 32'h1, 0, 0, 7'h00, 1);
    drain();
    check("queue_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
